regfile_mp: RTL and testbench



---
 rtl/regfile_mp_if.sv | 28 ++
 rtl/regfile_mp.sv | 75 +++++++
 tb/tb_regfile_mp.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read and clear-sweep bus of the multi-port register file.
interface regfile_mp_if #(
    parameter int data_bits  = 16,
    parameter int reg_count  = 16,
    parameter int read_ports = 2
) ();
    localparam int reg_addr_width = $clog2(reg_count);
    logic                                 W0_En;
    logic [reg_addr_width-1:0]            W0_Addr;
    logic [data_bits-1:0]                 W0_Data;
    logic                                 W1_En;
    logic [reg_addr_width-1:0]            W1_Addr;
    logic [data_bits-1:0]                 W1_Data;
    logic [read_ports*reg_addr_width-1:0] Read_Addr;
    logic [read_ports*data_bits-1:0]      Read_Data;
    logic [read_ports-1:0]                Read_Valid;
    logic                                 Clear_Req;
    logic                                 Busy;
    logic                                 Clear_Done;
    modport master (
        output W0_En, W0_Addr, W0_Data, W1_En, W1_Addr, W1_Data, Read_Addr, Clear_Req,
        input  Read_Data, Read_Valid, Busy, Clear_Done
    );
    modport slave (
        input  W0_En, W0_Addr, W0_Data, W1_En, W1_Addr, W1_Data, Read_Addr, Clear_Req,
        output Read_Data, Read_Valid, Busy, Clear_Done
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, two prioritised write ports, valid bits and a clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_mp #(
    parameter int data_bits  = 16,
    parameter int reg_count  = 16,
    parameter int read_ports = 2
) (
    input logic         Clk,
    input logic         Reset,
    regfile_mp_if.slave bus
);
    localparam int reg_addr_width = $clog2(reg_count);
    localparam logic [reg_addr_width-1:0] last_addr = reg_addr_width'(reg_count - 1);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
    state_t                    state_q, state_d;
    logic [reg_addr_width-1:0] cnt_q, cnt_d;
    logic [data_bits-1:0]      regs_q [reg_count];
    logic [data_bits-1:0]      regs_d [reg_count];
    logic [reg_count-1:0]      valid_q, valid_d;
    logic                      wr_ok;
    assign wr_ok          = state_q != CLEAR;
    assign bus.Busy       = state_q == CLEAR;
    assign bus.Clear_Done = state_q == DONE;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            regs_q  <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            regs_q  <= regs_d;
        end
    end
    // W1 is applied after W0 so it wins an address collision
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        valid_d = valid_q;
        if (!wr_ok) begin
            regs_d[cnt_q]  = '0;
            valid_d[cnt_q] = 1'b0;
            cnt_d          = cnt_q + 1'b1;
            state_d        = cnt_q == last_addr ? DONE : CLEAR;
        end else begin
            if (bus.W0_En) begin
                regs_d[bus.W0_Addr]  = bus.W0_Data;
                valid_d[bus.W0_Addr] = 1'b1;
            end
            if (bus.W1_En) begin
                regs_d[bus.W1_Addr]  = bus.W1_Data;
                valid_d[bus.W1_Addr] = 1'b1;
            end
            cnt_d   = '0;
            state_d = state_q == IDLE && bus.Clear_Req ? CLEAR : IDLE;
        end
    end
    for (genvar k = 0; k < read_ports; k++) begin : g_rd
        logic [reg_addr_width-1:0] ra;
        assign ra = bus.Read_Addr[k*reg_addr_width +: reg_addr_width];
`ifdef REGFILE_BYPASS_EN
        logic hit0, hit1;
        assign hit0 = wr_ok && bus.W0_En && bus.W0_Addr == ra;
        assign hit1 = wr_ok && bus.W1_En && bus.W1_Addr == ra;
        assign bus.Read_Data[k*data_bits +: data_bits] = hit1 ? bus.W1_Data : hit0 ? bus.W0_Data : regs_q[ra];
        assign bus.Read_Valid[k] = hit0 | hit1 | valid_q[ra];
`else
        assign bus.Read_Data[k*data_bits +: data_bits] = regs_q[ra];
        assign bus.Read_Valid[k] = valid_q[ra];
`endif
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench comparing regfile_mp against an array-level model.
module tb_regfile_mp;
    localparam int DB = 16, RC = 16, RP = 2, AW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    regfile_mp_if #(.data_bits(DB), .reg_count(RC), .read_ports(RP)) bus ();
    regfile_mp #(.data_bits(DB), .reg_count(RC), .read_ports(RP)) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );
    typedef struct {
        string            tag;
        logic [RP*DB-1:0] rd;
        logic [RP-1:0]    rv;
        logic             busy;
        logic             done;
    } exp_t;
    exp_t            q[$];
    int              vectors = 0, miscompares = 0;
    logic [DB-1:0]   mem [RC];
    logic            vld [RC];
    int              sweep_pos = -1;
    bit              done_f = 0;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (bus.Read_Data !== e.rd || bus.Read_Valid !== e.rv || bus.Busy !== e.busy || bus.Clear_Done !== e.done) begin
                miscompares++;
                $display("FAIL %s: got rd=%h rv=%b busy=%b done=%b, want rd=%h rv=%b busy=%b done=%b",
                         e.tag, bus.Read_Data, bus.Read_Valid, bus.Busy, bus.Clear_Done, e.rd, e.rv, e.busy, e.done);
            end
        end
    end
    task automatic model_reset();
        for (int i = 0; i < RC; i++) begin
            mem[i] = '0;
            vld[i] = 1'b0;
        end
        sweep_pos = -1;
        done_f    = 0;
    endtask
    function automatic exp_t expect_now(string t);
        exp_t e;
        e.tag = t;
        for (int k = 0; k < RP; k++) begin
            logic [AW-1:0] a;
            logic [DB-1:0] d;
            logic          v;
            a = bus.Read_Addr[k*AW +: AW];
            d = mem[a];
            v = vld[a];
`ifdef REGFILE_BYPASS_EN
            if (sweep_pos < 0) begin
                if (bus.W1_En && bus.W1_Addr == a) begin
                    d = bus.W1_Data;
                    v = 1'b1;
                end else if (bus.W0_En && bus.W0_Addr == a) begin
                    d = bus.W0_Data;
                    v = 1'b1;
                end
            end
`endif
            e.rd[k*DB +: DB] = d;
            e.rv[k]          = v;
        end
        e.busy = sweep_pos >= 0;
        e.done = done_f;
        return e;
    endfunction
    task automatic model_edge();
        if (sweep_pos >= 0) begin
            mem[sweep_pos] = '0;
            vld[sweep_pos] = 1'b0;
            sweep_pos++;
            if (sweep_pos == RC) begin
                sweep_pos = -1;
                done_f    = 1;
            end
        end else begin
            bit was_done;
            was_done = done_f;
            done_f   = 0;
            if (bus.W0_En) begin
                mem[bus.W0_Addr] = bus.W0_Data;
                vld[bus.W0_Addr] = 1'b1;
            end
            if (bus.W1_En) begin
                mem[bus.W1_Addr] = bus.W1_Data;
                vld[bus.W1_Addr] = 1'b1;
            end
            if (bus.Clear_Req && !was_done) sweep_pos = 0;
        end
    endtask
    task automatic cycle(string t);
        q.push_back(expect_now(t));
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic wr(bit e0, int a0, int d0, bit e1, int a1, int d1);
        bus.W0_En   = e0;
        bus.W0_Addr = AW'(a0);
        bus.W0_Data = DB'(d0);
        bus.W1_En   = e1;
        bus.W1_Addr = AW'(a1);
        bus.W1_Data = DB'(d1);
    endtask
    task automatic rd(int a0, int a1);
        bus.Read_Addr = {AW'(a1), AW'(a0)};
    endtask
    task automatic idle();
        wr(0, 0, 0, 0, 0, 0);
        bus.Clear_Req = 1'b0;
    endtask
    task automatic mid_reset(string t);
        idle();
        rst = 1'b1;
        model_reset();
        q.push_back(expect_now(t));
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask
    task automatic read_all(string t);
        idle();
        for (int i = 0; i < RC / 2; i++) begin
            rd(2 * i, 2 * i + 1);
            cycle(t);
        end
    endtask
    task automatic rand_cycle(string t, int clr_odds);
        wr($urandom % 2, $urandom, $urandom, $urandom % 2, $urandom, $urandom);
        bus.Clear_Req = clr_odds > 0 && ($urandom % clr_odds) == 0;
        rd($urandom, $urandom);
        cycle(t);
    endtask
    initial begin
        idle();
        rd(0, 1);
        model_reset();
        @(posedge clk);
        #1;
        mid_reset("reset_state");
        read_all("reset_read");
        wr(1, 3, 'h1234, 1, 7, 'hBEEF);
        rd(3, 7);
        cycle("dual_wr");
        idle();
        cycle("dual_rd");
        wr(1, 5, 'hAAAA, 1, 5, 'h5555);
        rd(5, 5);
        cycle("collision_wr");
        idle();
        cycle("collision_rd");
        wr(0, 0, 0, 1, 9, 'h1111);
        cycle("bypass_seed");
        wr(0, 0, 0, 1, 9, 'hC0DE);
        rd(0, 9);
        cycle("bypass_same");
        idle();
        cycle("bypass_after");
        for (int i = 0; i < 300; i++) rand_cycle("random", 60);
        for (int i = 0; i < 20; i++) rand_cycle("random_settle", 0);
        mid_reset("reset_loaded");
        read_all("reset_loaded_read");
        for (int i = 0; i < RC / 2; i++) begin
            wr(1, 2 * i, 'h100 + 2 * i, 1, 2 * i + 1, 'h101 + 2 * i);
            rd($urandom, $urandom);
            cycle("fill");
        end
        read_all("fill_read");
        bus.Clear_Req = 1'b1;
        rd(2, 15);
        cycle("sweep_req");
        bus.Clear_Req = 1'b0;
        for (int i = 0; i < RC; i++) begin
            if (i == 3) wr(1, 2, 'hFFFF, 1, 14, 'hFFFF);
            else idle();
            rd(i == 3 ? 2 : $urandom, i);
            cycle("sweep_busy");
        end
        wr(1, 4, 'h4444, 0, 0, 0);
        bus.Clear_Req = 1'b1;
        rd(4, 2);
        cycle("sweep_done");
        idle();
        rd(4, 2);
        cycle("after_done");
        read_all("sweep_read");
        for (int i = 0; i < 6; i++) begin
            wr(1, i, 'hA0 + i, 1, 15 - i, 'hB0 + i);
            cycle("prefill");
        end
        bus.Clear_Req = 1'b1;
        cycle("sweep2_req");
        idle();
        for (int i = 1; i < 6; i++) begin
            rd(i, 15);
            cycle("sweep2_busy");
        end
        mid_reset("reset_mid_sweep");
        read_all("mid_sweep_read");
        for (int i = 0; i < 20; i++) begin
            rd($urandom, $urandom);
            cycle("no_done");
        end
        for (int i = 0; i < 200; i++) rand_cycle("random2", 25);
        idle();
        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
